// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the sync_memory_p slice.
//   - default values for the word width, address width and read latency
//   - the two-state controller enum used by the top level
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_W_DEF = 8;
  localparam int MEM_ADDR_W_DEF = 5;
  localparam int MEM_RD_LAT_DEF = 1;

  // CLEAR sweeps zeros through the whole array; READY services rd/wr/clr.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem_rd_pipe
// RD_LAT-stage delay line carrying read data and its valid flag from the
// array read port to the block outputs.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (clears valids and data)
//   valid_i  in   a read is issued this cycle
//   data_i   in   array word addressed by the issued read
//   valid_o  out  last stage holds a fresh read result
//   data_o   out  last stage data, held while no new result arrives
// ---------------------------------------------------------------------------
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W_DEF,
  parameter int RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [DATA_W-1:0] data_q [RD_LAT];

  // A data stage only loads when the stage feeding it is valid, so the last
  // stage keeps its previous result between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/sync_memory_p.sv
// ---------------------------------------------------------------------------
// sync_memory_p
// Single-port synchronous-write memory with a hardware zero-sweep and a
// configurable read latency.  After reset, and on every accepted clr pulse,
// the controller walks every location writing zero; requests are ignored
// while that sweep runs.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   pulse requesting a full-array zero sweep
//   rd        in   read request
//   wr        in   write request (wins over rd in the same cycle)
//   addr      in   word address for rd/wr
//   data_in   in   write data
//   data_out  out  registered read data, held between reads
//   rd_valid  out  data_out carries a new read result this cycle
//   busy      out  zero sweep in progress
// ---------------------------------------------------------------------------
module sync_memory_p
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W_DEF,
  parameter int ADDR_W = MEM_ADDR_W_DEF,
  parameter int RD_LAT = MEM_RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_issue;

  // Controller: the array write port is shared between the sweep and user
  // writes.  clr beats wr, and wr beats rd.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    rd_issue  = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else if (wr) begin
          mem_we = 1'b1;
        end else if (rd) begin
          rd_issue = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // No reset on the array so it maps onto RAM; the sweep does the zeroing.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // The first pipe stage captures the addressed word at the request edge,
  // which is the registered read port of the RAM.
  mem_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(rd_issue),
    .data_i (mem_q[addr]),
    .valid_o(rd_valid),
    .data_o (data_out)
  );

  assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_sync_memory_p.sv
// ---------------------------------------------------------------------------
// tb_sync_memory_p
// Drives three copies of sync_memory_p (read latency 1, 2 and 4) with the
// same directed stimulus and checks them against a behavioural model plus
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sync_memory_p;

  logic       clock  = 1'b0;
  logic       rstN   = 1'b0;
  logic       clr    = 1'b0;
  logic       rd     = 1'b0;
  logic       wr     = 1'b0;
  logic [4:0] addr   = '0;
  logic [7:0] dataIn = '0;

  logic [2:0][7:0] dOut;
  logic [2:0]      vOut;
  logic [2:0]      bOut;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  sync_memory_p #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) dutLat1 (
    .clk(clock), .rst_n(rstN), .clr(clr), .rd(rd), .wr(wr), .addr(addr),
    .data_in(dataIn), .data_out(dOut[0]), .rd_valid(vOut[0]), .busy(bOut[0])
  );

  sync_memory_p #(.DATA_W(8), .ADDR_W(5), .RD_LAT(2)) dutLat2 (
    .clk(clock), .rst_n(rstN), .clr(clr), .rd(rd), .wr(wr), .addr(addr),
    .data_in(dataIn), .data_out(dOut[1]), .rd_valid(vOut[1]), .busy(bOut[1])
  );

  sync_memory_p #(.DATA_W(8), .ADDR_W(5), .RD_LAT(4)) dutLat4 (
    .clk(clock), .rst_n(rstN), .clr(clr), .rd(rd), .wr(wr), .addr(addr),
    .data_in(dataIn), .data_out(dOut[2]), .rd_valid(vOut[2]), .busy(bOut[2])
  );

  function automatic int latOf(int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: an array, a count of sweep cycles still to run, and a
  // short history of which edges issued a read and with what data.  Output k
  // must show the read issued latOf(k) edges back.
  logic [7:0] mMem [32];
  int         busyLeft = 32;
  bit         hv [4];
  logic [7:0] hd [4];
  logic [7:0] expOut [3];
  bit         mIssue;
  logic [7:0] mData;

  always @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      busyLeft = 32;
      for (int i = 0; i < 32; i++) mMem[i] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        hv[i] = 1'b0;
        hd[i] = 8'h00;
      end
      for (int k = 0; k < 3; k++) expOut[k] = 8'h00;
    end else begin
      mIssue = 1'b0;
      mData  = 8'h00;
      if (busyLeft > 0) begin
        busyLeft--;
      end else if (clr) begin
        busyLeft = 32;
        for (int i = 0; i < 32; i++) mMem[i] = 8'h00;
      end else if (wr) begin
        mMem[addr] = dataIn;
      end else if (rd) begin
        mIssue = 1'b1;
        mData  = mMem[addr];
      end
      for (int i = 3; i > 0; i--) begin
        hv[i] = hv[i-1];
        hd[i] = hd[i-1];
      end
      hv[0] = mIssue;
      hd[0] = mData;
      for (int k = 0; k < 3; k++) begin
        if (hv[latOf(k)-1]) expOut[k] = hd[latOf(k)-1];
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("model busy lat%0d", latOf(k)), 32'(bOut[k]), 32'(busyLeft > 0));
        checkOutput($sformatf("model rd_valid lat%0d", latOf(k)), 32'(vOut[k]), 32'(hv[latOf(k)-1]));
        checkOutput($sformatf("model data_out lat%0d", latOf(k)), 32'(dOut[k]), 32'(expOut[k]));
      end
    end
  end

  // One-cycle request pulse; called at a falling edge, returns at the next one
  // with all requests idle again.
  task automatic applyStimulus(bit c, bit r, bit w, logic [4:0] a, logic [7:0] d);
    clr    = c;
    rd     = r;
    wr     = w;
    addr   = a;
    dataIn = d;
    @(negedge clock);
    clr = 1'b0;
    rd  = 1'b0;
    wr  = 1'b0;
  endtask

  // Counts falling-edge samples with busy high, starting now.
  task automatic sweepCount(string name, int expCycles);
    int cnt = 0;
    while (bOut[1] && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    checkOutput(name, cnt, expCycles);
  endtask

  // Issues n (1 or 2) back-to-back reads and checks, for each latency, when
  // rd_valid pulses and what data_out shows.
  task automatic readSeq(string name, logic [4:0] a0, logic [4:0] a1,
                         logic [7:0] e0, logic [7:0] e1, int n);
    int         cntV [3];
    int         at0 [3];
    int         at1 [3];
    logic [7:0] got0 [3];
    logic [7:0] got1 [3];
    for (int k = 0; k < 3; k++) begin
      cntV[k] = 0; at0[k] = 0; at1[k] = 0; got0[k] = 8'h00; got1[k] = 8'h00;
    end
    rd   = 1'b1;
    addr = a0;
    @(negedge clock);
    for (int c = 1; c <= 7; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (vOut[k]) begin
          if (cntV[k] == 0) begin
            at0[k] = c; got0[k] = dOut[k];
          end else if (cntV[k] == 1) begin
            at1[k] = c; got1[k] = dOut[k];
          end
          cntV[k]++;
        end
      end
      if (c == 1 && n == 2) addr = a1;
      else                  rd   = 1'b0;
      @(negedge clock);
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s lat%0d pulses", name, latOf(k)), cntV[k], n);
      checkOutput($sformatf("%s lat%0d first latency", name, latOf(k)), at0[k], latOf(k));
      checkOutput($sformatf("%s lat%0d first data", name, latOf(k)), 32'(got0[k]), 32'(e0));
      if (n == 2) begin
        checkOutput($sformatf("%s lat%0d second latency", name, latOf(k)), at1[k], latOf(k) + 1);
        checkOutput($sformatf("%s lat%0d second data", name, latOf(k)), 32'(got1[k]), 32'(e1));
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         busyCnt;
    int         at0 [3];
    logic [7:0] got0 [3];
    int         vCnt;

    // Reset state, then the power-up sweep and a read of a swept location.
    repeat (3) @(negedge clock);
    checkOutput("reset data_out", 32'(dOut), 32'h0);
    checkOutput("reset rd_valid", 32'(vOut), 32'h0);
    checkOutput("reset busy", 32'(bOut), 32'h7);
    rstN = 1'b1;
    sweepCount("initial sweep length", 32);
    readSeq("read 0x0F after sweep", 5'h0F, 5'h00, 8'h00, 8'h00, 1);

    // Two writes, then two back-to-back reads.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h05, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h0A, 8'hAA);
    readSeq("b2b 0x05/0x0A", 5'h05, 5'h0A, 8'hA5, 8'hAA, 2);

    // rd and wr together: write only, no read result.
    applyStimulus(1'b0, 1'b1, 1'b1, 5'h15, 8'h55);
    vCnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (vOut != 3'b000) vCnt++;
      @(negedge clock);
    end
    checkOutput("rd+wr gives no rd_valid", vCnt, 0);
    readSeq("read 0x15 after rd+wr", 5'h15, 5'h00, 8'h55, 8'h00, 1);

    // Highest and lowest addresses; read on the cycle right after a write.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h1F, 8'h81);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h00, 8'h18);
    readSeq("edges 0x1F/0x00", 5'h1F, 5'h00, 8'h81, 8'h18, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h09, 8'hC3);
    readSeq("read right after write", 5'h09, 5'h00, 8'hC3, 8'h00, 1);

    // clr with a same-cycle write drops the write; clr/wr during the sweep
    // are ignored and do not restart it.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'h02, 8'hEE);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'h02, 8'hEE);
    sweepCount("sweep not restarted by clr", 31);
    readSeq("read 0x02 after clr+wr", 5'h02, 5'h00, 8'h00, 8'h00, 1);

    // clr while a read is in flight.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h07, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      at0[k] = 0; got0[k] = 8'h00;
    end
    busyCnt = 0;
    rd   = 1'b1;
    addr = 5'h07;
    @(negedge clock);
    rd = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (vOut[k] && at0[k] == 0) begin
          at0[k] = c; got0[k] = dOut[k];
        end
      end
      if (bOut[1]) busyCnt++;
      clr = (c == 1);
      @(negedge clock);
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("in-flight read lat%0d latency", latOf(k)), at0[k], latOf(k));
      checkOutput($sformatf("in-flight read lat%0d data", latOf(k)), 32'(got0[k]), 32'h3C);
    end
    checkOutput("clr sweep length", busyCnt, 32);
    readSeq("read 0x07 after clr", 5'h07, 5'h00, 8'h00, 8'h00, 1);

    // Reset in the middle of a read.
    applyStimulus(1'b0, 1'b0, 1'b1, 5'h03, 8'h77);
    readSeq("read 0x03", 5'h03, 5'h00, 8'h77, 8'h77, 1);
    rd   = 1'b1;
    addr = 5'h03;
    @(negedge clock);
    rd = 1'b0;
    @(negedge clock);
    checkOutput("lat2 valid before reset", 32'(vOut[1]), 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("mid-read reset data_out", 32'(dOut), 32'h0);
    checkOutput("mid-read reset rd_valid", 32'(vOut), 32'h0);
    checkOutput("mid-read reset busy", 32'(bOut), 32'h7);
    @(negedge clock);
    rstN = 1'b1;
    sweepCount("sweep after mid-read reset", 32);

    // Reset at sweep_cnt = 10.
    rstN = 1'b0;
    @(negedge clock);
    rstN = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("busy at sweep_cnt 10", 32'(bOut), 32'h7);
    rstN = 1'b0;
    #1;
    checkOutput("mid-sweep reset data_out", 32'(dOut), 32'h0);
    checkOutput("mid-sweep reset rd_valid", 32'(vOut), 32'h0);
    @(negedge clock);
    rstN = 1'b1;
    sweepCount("full sweep after mid-sweep reset", 32);
    readSeq("read 0x05 after resets", 5'h05, 5'h03, 8'h00, 8'h00, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
